// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the packed-song bus.
//   - note / octave code constants and the mid-octave pitch table
//   - slice widths of the packed buses and the slot count of one image
//   - player FSM state type
//   - half_period(): speaker half-period in clocks for a (note, octave)
package song_pkg;

    localparam int NOTES  = 56;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 4;
    localparam int OCT_W  = 2;
    localparam int HP_W   = 18;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_SO   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_SI   = 4'd7;

    localparam logic [OCT_W-1:0] OCT_LOW  = 2'd0;
    localparam logic [OCT_W-1:0] OCT_MID  = 2'd1;
    localparam logic [OCT_W-1:0] OCT_HIGH = 2'd2;

    localparam int FREQ_DO = 523;
    localparam int FREQ_RE = 587;
    localparam int FREQ_MI = 659;
    localparam int FREQ_FA = 698;
    localparam int FREQ_SO = 784;
    localparam int FREQ_LA = 880;
    localparam int FREQ_SI = 988;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Rest codes (0 and 8..15) return 0, which the tone generator treats as
    // silence. clk_hz is a constant at every call site, so each branch folds
    // to a constant and the function reduces to a small mux.
    function automatic logic [HP_W-1:0] half_period(input logic [NOTE_W-1:0] note,
                                                     input logic [OCT_W-1:0]  oct,
                                                     input int                clk_hz);
        int              mid;
        logic [HP_W-1:0] hp;
        case (note)
            NOTE_DO: mid = clk_hz / (2 * FREQ_DO);
            NOTE_RE: mid = clk_hz / (2 * FREQ_RE);
            NOTE_MI: mid = clk_hz / (2 * FREQ_MI);
            NOTE_FA: mid = clk_hz / (2 * FREQ_FA);
            NOTE_SO: mid = clk_hz / (2 * FREQ_SO);
            NOTE_LA: mid = clk_hz / (2 * FREQ_LA);
            NOTE_SI: mid = clk_hz / (2 * FREQ_SI);
            default: mid = 0;
        endcase
        case (oct)
            OCT_LOW:  hp = HP_W'(mid * 2);
            OCT_HIGH: hp = HP_W'(mid >> 1);
            default:  hp = HP_W'(mid);      // mid, and code 3 played as mid
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/song_player_tone_gen.sv
// tone_gen: square-wave divider for the speaker pin.
//   clk, rst_n   : clock, async active-low reset
//   restart      : clears divider and drives speaker low on the next edge
//   half_period  : clocks per half wave; 0 means silence
//   enable       : run the divider; when low the output is held at 0
//   speaker      : square-wave output
module tone_gen
    import song_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    input  logic [HP_W-1:0] half_period,
    input  logic            enable,
    output logic            speaker
);

    logic [HP_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            speaker <= 1'b0;
        end else if (restart || !enable || half_period == '0) begin
            div_cnt <= '0;
            speaker <= 1'b0;
        end else if (div_cnt == half_period - 1'b1) begin
            div_cnt <= '0;
            speaker <= ~speaker;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/song_player.sv
// song_player: plays one latched song image on the speaker pin.
//   start / stop                : level controls (start begins from idle, stop aborts)
//   song_packed / time_continue : 4-bit note / duration codes, slot 0 in the MSBs
//   octave_packed               : 2-bit octave codes, slot 0 in the MSBs
//   busy, done                  : playing flag, one-cycle end-of-song pulse
//   note_idx/note_code/note_oct : slot currently sounding
//   speaker                     : square-wave audio
//   state_dbg                   : FSM state, for observation only
// Handshake: start is a level sampled every cycle; it is honoured only in
// IDLE with stop low. stop is honoured in PLAY and beats a slot boundary.
module song_player #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_CYCLES = 12_500_000,
    parameter int NOTES       = song_pkg::NOTES
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic [NOTES*song_pkg::NOTE_W-1:0] song_packed,
    input  logic [NOTES*song_pkg::DUR_W-1:0]  time_continue,
    input  logic [NOTES*song_pkg::OCT_W-1:0]  octave_packed,
    output logic                              busy,
    output logic                              done,
    output logic [5:0]                        note_idx,
    output logic [3:0]                        note_code,
    output logic [1:0]                        note_oct,
    output logic                              speaker,
    output song_pkg::state_t                  state_dbg
);
    import song_pkg::*;

    state_t state, state_nx;

    logic [NOTE_W-1:0] img_note [NOTES];
    logic [DUR_W-1:0]  img_dur  [NOTES];
    logic [OCT_W-1:0]  img_oct  [NOTES];

    logic [23:0]      beat_cnt;
    logic [3:0]       unit_cnt;
    logic [DUR_W-1:0] dur_eff;
    logic [5:0]       idx_nx;
    logic             beat_last, unit_last;
    logic             load, slot_end;
    logic [HP_W-1:0]  tone_hp;
    logic             tone_restart;

    // Duration code 0 plays as one unit.
    assign dur_eff   = (img_dur[note_idx] == '0) ? DUR_W'(1) : img_dur[note_idx];
    assign idx_nx    = note_idx + 6'd1;
    assign beat_last = (beat_cnt == 24'(TICK_CYCLES - 1));
    assign unit_last = ((unit_cnt + 4'd1) == dur_eff);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        slot_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nx = ST_PLAY;
                    load     = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (beat_last && unit_last) begin
                    slot_end = 1'b1;
                    if (note_idx == 6'(NOTES - 1)) state_nx = ST_FINISH;
                end
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOTES; i++) begin
                img_note[i] <= '0;
                img_dur[i]  <= '0;
                img_oct[i]  <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NOTES; i++) begin
                img_note[i] <= song_packed[(NOTES-1-i)*NOTE_W +: NOTE_W];
                img_dur[i]  <= time_continue[(NOTES-1-i)*DUR_W +: DUR_W];
                img_oct[i]  <= octave_packed[(NOTES-1-i)*OCT_W +: OCT_W];
            end
        end
    end

    // busy drops and done pulses on the edge that leaves FINISH, so both
    // are seen together in the cycle after the last slot's FINISH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            note_idx  <= '0;
            note_code <= '0;
            note_oct  <= '0;
            beat_cnt  <= '0;
            unit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Slot 0 is taken straight from the bus on the latch edge.
                busy      <= 1'b1;
                note_idx  <= '0;
                note_code <= song_packed[(NOTES-1)*NOTE_W +: NOTE_W];
                note_oct  <= octave_packed[(NOTES-1)*OCT_W +: OCT_W];
                beat_cnt  <= '0;
                unit_cnt  <= '0;
            end else if (state == ST_PLAY) begin
                if (stop) begin
                    busy     <= 1'b0;
                    beat_cnt <= '0;
                    unit_cnt <= '0;
                end else if (slot_end) begin
                    beat_cnt <= '0;
                    unit_cnt <= '0;
                    if (state_nx == ST_PLAY) begin
                        note_idx  <= idx_nx;
                        note_code <= img_note[idx_nx];
                        note_oct  <= img_oct[idx_nx];
                    end
                end else if (beat_last) begin
                    beat_cnt <= '0;
                    unit_cnt <= unit_cnt + 4'd1;
                end else begin
                    beat_cnt <= beat_cnt + 24'd1;
                end
            end else if (state == ST_FINISH) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Every slot boundary, stop and non-PLAY cycle restarts the tone so a
    // note always begins with the speaker low.
    assign tone_hp      = half_period(note_code, note_oct, CLK_HZ);
    assign tone_restart = (state != ST_PLAY) || slot_end || stop;

    tone_gen u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (tone_restart),
        .half_period (tone_hp),
        .enable      (state == ST_PLAY),
        .speaker     (speaker)
    );

endmodule

// File: tb/tb_song_player.sv
module tb_song_player;
    localparam int CLK_HZ = 1_046_000;
    localparam int TICK   = 4;
    localparam int TICK_T = 4000;
    localparam int N      = 56;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // main instance (TICK = 4)
    logic           start = 1'b0, stop = 1'b0;
    logic [N*4-1:0] song_packed = '0, time_continue = '0;
    logic [N*2-1:0] octave_packed = '0;
    logic           busy, done, speaker;
    logic [5:0]     note_idx;
    logic [3:0]     note_code;
    logic [1:0]     note_oct;
    song_pkg::state_t state_dbg;

    // tone instance (TICK = 4000) for audible square waves
    logic           start_t = 1'b0, stop_t = 1'b0;
    logic [N*4-1:0] song_t = '0, time_t = '0;
    logic [N*2-1:0] oct_t = '0;
    logic           busy_t, done_t, speaker_t;
    logic [5:0]     note_idx_t;
    logic [3:0]     note_code_t;
    logic [1:0]     note_oct_t;
    song_pkg::state_t state_dbg_t;

    song_player #(.CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK), .NOTES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .song_packed(song_packed), .time_continue(time_continue), .octave_packed(octave_packed),
        .busy(busy), .done(done), .note_idx(note_idx), .note_code(note_code),
        .note_oct(note_oct), .speaker(speaker), .state_dbg(state_dbg)
    );

    song_player #(.CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK_T), .NOTES(N)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .stop(stop_t),
        .song_packed(song_t), .time_continue(time_t), .octave_packed(oct_t),
        .busy(busy_t), .done(done_t), .note_idx(note_idx_t), .note_code(note_code_t),
        .note_oct(note_oct_t), .speaker(speaker_t), .state_dbg(state_dbg_t)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    int m_note[N], m_dur[N], m_oct[N];
    int freq_tab[8] = '{0, 523, 587, 659, 698, 784, 880, 988};

    function automatic int hp_model(input int n, input int o);
        int mid;
        if (n < 1 || n > 7) return 0;
        mid = CLK_HZ / (2 * freq_tab[n]);
        if (o == 0) return mid * 2;
        if (o == 2) return mid / 2;
        return mid;
    endfunction

    function automatic int slot_start(input int e, input int i);
        int t;
        t = e;
        for (int j = 0; j < i; j++) t += ((m_dur[j] == 0) ? 1 : m_dur[j]) * TICK;
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        busy;
        logic        done;
        logic [5:0]  idx;
        logic        chk_note;
        logic [3:0]  code;
        logic [1:0]  oct;
        logic [31:0] cyc;
    } ev_t;
    localparam int EV_W = $bits(ev_t);
    logic [EV_W-1:0] exp_q[$];

    task automatic push_ev(input logic b, input logic d, input int idx, input logic chk,
                           input int code, input int oct, input int c);
        ev_t ev;
        ev.busy = b; ev.done = d; ev.idx = 6'(idx); ev.chk_note = chk;
        ev.code = 4'(code); ev.oct = 2'(oct); ev.cyc = 32'(c);
        exp_q.push_back(ev);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: an event is any busy edge, note_idx change or done pulse.
    logic p_busy = 1'b0;
    logic [5:0] p_idx = '0;
    int spk_hot = 0;
    always @(negedge clk) begin
        ev_t ex;
        if (speaker !== 1'b0) spk_hot++;
        if (busy !== p_busy || note_idx !== p_idx || done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: cyc=%0d busy=%0b done=%0b idx=%0d, want no event",
                         cyc, busy, done, note_idx);
            end else begin
                ex = exp_q.pop_front();
                if (busy !== ex.busy || done !== ex.done || note_idx !== ex.idx || cyc != int'(ex.cyc) ||
                    (ex.chk_note && (note_code !== ex.code || note_oct !== ex.oct))) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d busy=%0b done=%0b idx=%0d code=%0d oct=%0d, want cyc=%0d busy=%0b done=%0b idx=%0d code=%0d oct=%0d",
                             cyc, busy, done, note_idx, note_code, note_oct,
                             ex.cyc, ex.busy, ex.done, ex.idx, ex.code, ex.oct);
                end
            end
        end
        p_busy = busy;
        p_idx  = note_idx;
    end

    // ---------------- driver tasks ----------------
    task automatic rand_image();
        for (int i = 0; i < N; i++) begin
            m_note[i] = $urandom_range(0, 15);
            m_dur[i]  = $urandom_range(0, 15);
            m_oct[i]  = $urandom_range(0, 3);
        end
    endtask

    task automatic load_buses();
        for (int i = 0; i < N; i++) begin
            song_packed[(N-1-i)*4 +: 4]   = 4'(m_note[i]);
            time_continue[(N-1-i)*4 +: 4] = 4'(m_dur[i]);
            octave_packed[(N-1-i)*2 +: 2] = 2'(m_oct[i]);
        end
    endtask

    // Pulses start; pushes slots 0..upto, plus done when the whole song is expected.
    task automatic start_song(input int upto, output int e);
        @(negedge clk);
        e = cyc + 1;
        for (int i = 0; i <= upto; i++)
            push_ev(1'b1, 1'b0, i, 1'b1, m_note[i], m_oct[i], slot_start(e, i));
        if (upto == N - 1) push_ev(1'b0, 1'b1, N - 1, 1'b0, 0, 0, slot_start(e, N) + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d events pending after %0d cycles, want 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic tone_test();
        int tn[6] = '{1, 1, 3, 0, 9, 7};
        int to[6] = '{0, 1, 2, 1, 1, 3};
        int td[6] = '{1, 2, 1, 1, 1, 1};
        int e, len, hp, bad, first_k;
        logic expv, first_got, first_exp;
        for (int i = 0; i < N; i++) begin
            song_t[(N-1-i)*4 +: 4] = 4'($urandom_range(0, 15));
            time_t[(N-1-i)*4 +: 4] = 4'($urandom_range(1, 15));
            oct_t[(N-1-i)*2 +: 2]  = 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < 6; i++) begin
            song_t[(N-1-i)*4 +: 4] = 4'(tn[i]);
            time_t[(N-1-i)*4 +: 4] = 4'(td[i]);
            oct_t[(N-1-i)*2 +: 2]  = 2'(to[i]);
        end
        @(negedge clk);
        start_t = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start_t = 1'b0;
        for (int i = 0; i < 6; i++) begin
            len = td[i] * TICK_T;
            hp  = hp_model(tn[i], to[i]);
            bad = 0;
            first_k = 0; first_got = 1'b0; first_exp = 1'b0;
            for (int k = 0; k < len; k++) begin
                expv = (hp == 0) ? 1'b0 : (((k / hp) % 2) == 1);
                if (speaker_t !== expv) begin
                    if (bad == 0) begin
                        first_k = k; first_got = speaker_t; first_exp = expv;
                    end
                    bad++;
                end
                if (i == 5 && k == len - 1) stop_t = 1'b1;
                @(negedge clk);
            end
            n_checks++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL tone_slot%0d: %0d cycles wrong, first at k=%0d got %0b want %0b",
                         i, bad, first_k, first_got, first_exp);
            end
        end
        stop_t = 1'b0;
        check("tone_stop_busy", 32'(busy_t), 32'd0);
        check("tone_stop_idx", 32'(note_idx_t), 32'd5);
        check("tone_stop_speaker", 32'(speaker_t), 32'd0);
        check("tone_stop_done", 32'(done_t), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e, s11, pulses;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_idx", 32'(note_idx), 32'd0);
        check("rst_code", 32'(note_code), 32'd0);
        check("rst_oct", 32'(note_oct), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // slot 0 = do/mid/2 units; bus scrambled and start re-pulsed mid-song
        rand_image();
        m_note[0] = 1; m_oct[0] = 1; m_dur[0] = 2;
        load_buses();
        start_song(N - 1, e);
        while (cyc < e + 20) @(negedge clk);
        pulses = $urandom_range(2, 5);
        for (int p = 0; p < pulses; p++) begin
            song_packed   = {7{$urandom()}};
            octave_packed = {4{$urandom()}};
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end
        wait_drain("latched_song", 5000);

        // all rests, one unit each: done exactly 56*4+1 after busy rises
        for (int i = 0; i < N; i++) begin
            m_note[i] = (i % 2 == 0) ? 0 : $urandom_range(8, 15);
            m_dur[i]  = 1;
            m_oct[i]  = $urandom_range(0, 3);
        end
        load_buses();
        start_song(N - 1, e);
        wait_drain("all_rest", 1000);

        // stop on the edge where slot 10 would end: stop wins, idx stays 10
        rand_image();
        load_buses();
        start_song(10, e);
        s11 = slot_start(e, 11);
        push_ev(1'b0, 1'b0, 10, 1'b0, 0, 0, s11);
        while (cyc < s11 - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_speaker", 32'(speaker), 32'd0);
        check("stop_idx", 32'(note_idx), 32'd10);
        wait_drain("stop", 1000);

        // fresh start replays from slot 0
        rand_image();
        load_buses();
        start_song(N - 1, e);
        wait_drain("replay", 5000);

        // start together with stop does nothing
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check("start_stop_busy", 32'(busy), 32'd0);

        // duration code 0 plays as 4 cycles; async reset during slot 1
        rand_image();
        m_dur[0] = 0;
        m_dur[1] = $urandom_range(2, 15);
        load_buses();
        start_song(N - 1, e);
        while (cyc < e + 6) @(negedge clk);
        @(posedge clk);
        #2;
        exp_q.delete();
        push_ev(1'b0, 1'b0, 0, 1'b1, 0, 0, cyc);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_speaker", 32'(speaker), 32'd0);
        check("arst_idx", 32'(note_idx), 32'd0);
        check("arst_code", 32'(note_code), 32'd0);
        check("arst_oct", 32'(note_oct), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("arst", 50);

        tone_test();

        check("main_speaker_silent", 32'(spk_hot), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
